mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 25 ++
 rtl/mod_counter_if.sv | 26 ++
 rtl/counter_step.sv | 38 +++
 rtl/mod_counter.sv | 105 ++++++++++
 tb/tb_mod_counter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding, FSM state type and mode decode for mod_counter
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'b00,
        SATURATE = 2'b01,
        ONESHOT  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // The unused 2'b11 encoding behaves as WRAP.
    function automatic mode_e decode_mode(input logic [1:0] mode_bits);
        case (mode_bits)
            2'b01:   return SATURATE;
            2'b10:   return ONESHOT;
            default: return WRAP;
        endcase
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle between mod_counter and its driver
interface mod_counter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] D;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output en, up, mode, start, stop, load, load_val,
        input  D, tc, busy, done
    );

    modport slave (
        input  en, up, mode, start, stop, load, load_val,
        output D, tc, busy, done
    );
endinterface

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational next-count, terminal-hit and wrap computation
module counter_step
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             up_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             hit_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] term;
    logic             at_term;

    assign term    = up_i ? MAX : '0;
    assign at_term = (d_i == term);

    // Sitting on the terminal value: WRAP jumps to the other end, the others hold.
    always_comb begin
        next_o = d_i;
        wrap_o = 1'b0;
        if (at_term) begin
            if (mode_i == WRAP) begin
                wrap_o = 1'b1;
                next_o = up_i ? '0 : MAX;
            end
        end else begin
            next_o = up_i ? d_i + WIDTH'(1) : d_i - WIDTH'(1);
        end
    end

    assign hit_o = (next_o == term);

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with WRAP/SATURATE/ONESHOT modes and IDLE/RUN/DONE FSM
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    logic rst_meta_q;
    logic rst_sync_q;

    // Assert immediately, release two edges later so the first active edge is clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    mode_e            mode;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_next;
    logic             step_hit;
    logic             step_wrap;

    assign mode         = decode_mode(bus.mode);
    assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

    counter_step #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_step (
        .d_i    (count_q),
        .up_i   (bus.up),
        .mode_i (mode),
        .next_o (step_next),
        .hit_o  (step_hit),
        .wrap_o (step_wrap)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_clamped;
            if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else if (bus.stop && (state_q == RUN)) begin
            state_d = IDLE;
        end else if (bus.start && (state_q != RUN)) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        count_d = step_next;
                        tc_d    = step_hit & ~step_wrap;
                        if (step_hit && (mode != WRAP)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // ONESHOT rearms at the start end for the direction seen now.
                    if (mode == ONESHOT) begin
                        count_d = bus.up ? '0 : MAX;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.D    = count_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed scoreboard bench for mod_counter (WIDTH=4/MAX=9 and WIDTH=8/MAX=255)
module tb_mod_counter;

    localparam logic [1:0] WR  = 2'b00;
    localparam logic [1:0] SAT = 2'b01;
    localparam logic [1:0] OS  = 2'b10;

    logic clk;
    logic reset_a;
    logic reset_b;

    mod_counter_if #(.WIDTH(4)) ifa ();
    mod_counter_if #(.WIDTH(8)) ifb ();

    mod_counter #(.WIDTH(4), .MAX(4'd9)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa)
    );

    mod_counter #(.WIDTH(8), .MAX(8'd255)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         on_b;
        logic [7:0] d;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input bit on_b, input logic [7:0] d,
                        input logic tc, input logic busy, input logic done);
        exp_t e;
        e.tag  = tag;
        e.on_b = on_b;
        e.d    = d;
        e.tc   = tc;
        e.busy = busy;
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [10:0] obs;
        logic [10:0] exp_v;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: observed empty queue, required one pending entry");
        end else begin
            e = sb.pop_front();
            if (e.on_b) obs = {ifb.D, ifb.tc, ifb.busy, ifb.done};
            else        obs = {4'b0000, ifa.D, ifa.tc, ifa.busy, ifa.done};
            exp_v = {e.d, e.tc, e.busy, e.done};
            assert (obs === exp_v) else begin
                errors++;
                $display("FAIL %s: observed D=%0d tc=%0b busy=%0b done=%0b, required D=%0d tc=%0b busy=%0b done=%0b",
                         e.tag, obs[10:3], obs[2], obs[1], obs[0], e.d, e.tc, e.busy, e.done);
                $error("check %s", e.tag);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic en, input logic up, input logic [1:0] mode,
                       input logic start, input logic stop, input logic load, input logic [3:0] lv,
                       input logic [3:0] d, input logic tc, input logic busy, input logic done);
        ifa.en       = en;
        ifa.up       = up;
        ifa.mode     = mode;
        ifa.start    = start;
        ifa.stop     = stop;
        ifa.load     = load;
        ifa.load_val = lv;
        push(tag, 1'b0, {4'b0000, d}, tc, busy, done);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic cyc_b(input string tag, input logic en, input logic start,
                         input logic [7:0] d, input logic tc, input logic busy);
        ifb.en    = en;
        ifb.start = start;
        push(tag, 1'b1, d, tc, busy, 1'b0);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200us, required bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] wd_seq [4];
        wd_seq[0] = 4'd1; wd_seq[1] = 4'd0; wd_seq[2] = 4'd9; wd_seq[3] = 4'd8;

        reset_a = 1'b0;
        reset_b = 1'b0;
        ifa.en = 0; ifa.up = 1; ifa.mode = WR; ifa.start = 0; ifa.stop = 0; ifa.load = 0; ifa.load_val = '0;
        ifb.en = 0; ifb.up = 1; ifb.mode = WR; ifb.start = 0; ifb.stop = 0; ifb.load = 0; ifb.load_val = '0;

        repeat (2) @(posedge clk);
        #1;
        push("reset_a", 1'b0, 8'd0, 0, 0, 0); compare();
        push("reset_b", 1'b1, 8'd0, 0, 0, 0); compare();
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) cyc("idle", 0, 1, WR, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);

        // wrap up
        cyc("wu_start", 0, 1, WR, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
        for (int i = 1; i <= 12; i++)
            cyc("wrap_up", 1, 1, WR, 0, 0, 0, 4'd0, 4'(i % 10), (i == 9), 1, 0);
        cyc("wu_stop", 1, 1, WR, 0, 1, 0, 4'd0, 4'd2, 0, 0, 0);

        // wrap down
        cyc("wd_load", 0, 0, WR, 0, 0, 1, 4'd2, 4'd2, 0, 0, 0);
        cyc("wd_start", 0, 0, WR, 1, 0, 0, 4'd0, 4'd2, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            cyc("wrap_dn", 1, 0, WR, 0, 0, 0, 4'd0, wd_seq[i], (wd_seq[i] == 4'd0), 1, 0);
        cyc("wd_stop", 1, 0, WR, 0, 1, 0, 4'd0, 4'd8, 0, 0, 0);

        // saturate, then restart downward
        cyc("sat_load", 0, 1, SAT, 0, 0, 1, 4'd7, 4'd7, 0, 0, 0);
        cyc("sat_start", 0, 1, SAT, 1, 0, 0, 4'd0, 4'd7, 0, 1, 0);
        cyc("sat_8", 1, 1, SAT, 0, 0, 0, 4'd0, 4'd8, 0, 1, 0);
        cyc("sat_9", 1, 1, SAT, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1);
        repeat (2) cyc("sat_hold", 1, 1, SAT, 0, 0, 0, 4'd0, 4'd9, 0, 0, 1);
        cyc("sat_restart", 0, 0, SAT, 1, 0, 0, 4'd0, 4'd9, 0, 1, 0);
        cyc("sat_down", 1, 0, SAT, 0, 0, 0, 4'd0, 4'd8, 0, 1, 0);
        cyc("sat_stop", 1, 0, SAT, 0, 1, 0, 4'd0, 4'd8, 0, 0, 0);

        // step attempted while already at terminal
        cyc("sat_ld9", 0, 1, SAT, 0, 0, 1, 4'd9, 4'd9, 0, 0, 0);
        cyc("sat_st9", 0, 1, SAT, 1, 0, 0, 4'd0, 4'd9, 0, 1, 0);
        cyc("sat_at_t", 1, 1, SAT, 0, 0, 0, 4'd0, 4'd9, 1, 0, 1);
        cyc("done_load", 1, 1, SAT, 0, 0, 1, 4'd3, 4'd3, 0, 0, 0);

        // oneshot
        cyc("os_load0", 0, 1, OS, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
        cyc("os_start", 0, 1, OS, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
        for (int i = 1; i <= 9; i++)
            cyc("oneshot", 1, 1, OS, 0, 0, 0, 4'd0, 4'(i), (i == 9), (i != 9), (i == 9));
        cyc("os_release", 1, 1, OS, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        cyc("os_idle", 1, 1, OS, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);

        // priority and clamp
        cyc("clamp_idle", 0, 1, WR, 1, 1, 1, 4'd15, 4'd9, 0, 0, 0);
        cyc("pr_start", 0, 1, WR, 1, 0, 0, 4'd0, 4'd9, 0, 1, 0);
        cyc("clamp_run", 1, 1, WR, 1, 1, 1, 4'd15, 4'd9, 0, 1, 0);
        cyc("pr_wrap", 1, 1, WR, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
        for (int i = 1; i <= 5; i++)
            cyc("pr_cnt", 1, 1, WR, 0, 0, 0, 4'd0, 4'(i), 0, 1, 0);
        cyc("stop_hold", 1, 1, WR, 0, 1, 0, 4'd0, 4'd5, 0, 0, 0);
        cyc("idle_hold", 1, 1, WR, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0);

        // asynchronous reset mid-run
        cyc("ar_start", 0, 1, WR, 1, 0, 0, 4'd0, 4'd5, 0, 1, 0);
        cyc("ar_cnt", 1, 1, WR, 0, 0, 0, 4'd0, 4'd6, 0, 1, 0);
        #2;
        reset_a = 1'b0;
        #1;
        push("ar_now", 1'b0, 8'd0, 0, 0, 0); compare();
        @(posedge clk);
        #1;
        push("ar_held", 1'b0, 8'd0, 0, 0, 0); compare();
        reset_a = 1'b1;
        repeat (3) cyc("ar_release", 1, 1, WR, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);

        // WIDTH=8 full wrap
        cyc_b("b_start", 0, 1, 8'd0, 0, 1);
        for (int i = 1; i <= 256; i++)
            cyc_b("b_wrap", 1, 0, 8'(i % 256), (i == 255), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
